// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and field widths for the i2c command arbiter
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_MEM_W  = 5;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first request at or after the pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Scan N positions starting at the pointer, wrapping; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin command arbiter sharing one i2c_master among NREQ requesters
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [I2C_MEM_W*NREQ-1:0]  req_mem_addr,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]      rsp_data,
  output logic                       rsp_ack_err,
  output logic                       rsp_timeout,
  output logic                       m_en,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic                       m_rw,
  output logic [I2C_MEM_W-1:0]       m_mem_addr,
  output logic [I2C_DATA_W-1:0]      m_data_wr,
  input  logic [I2C_DATA_W-1:0]      m_data_rd,
  input  logic                       m_ack_err,
  input  logic                       m_busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TO - 1);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         gidx_q;
  logic [NREQ-1:0]       gnt_q;
  logic [NREQ-1:0]       done_q;
  logic [I2C_ADDR_W-1:0] addr_q;
  logic                  rw_q;
  logic [I2C_MEM_W-1:0]  mem_q;
  logic [I2C_DATA_W-1:0] wdata_q;
  logic [I2C_DATA_W-1:0] rsp_data_q;
  logic                  rsp_ack_err_q;
  logic                  rsp_timeout_q;

  logic                  to_hit;
  logic                  to_resp;

  logic [NREQ-1:0]       pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_valid;

  rr_pick #(
    .N  (NREQ),
    .IW (PW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state, launch pulse and start-timeout detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_hit  = 1'b0;
    m_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = LAUNCH;
      end
      LAUNCH: begin
        m_en    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_hit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!m_busy) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    to_resp = (state_d == RESP) && (state_q != RESP);
  end

  // State, command latch at grant, response capture on entry to RESP, pointer rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      gidx_q        <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      mem_q         <= '0;
      wdata_q       <= '0;
      rsp_data_q    <= '0;
      rsp_ack_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= '0;
      if (state_q == IDLE && pick_valid) begin
        gnt_q   <= pick_gnt;
        gidx_q  <= pick_idx;
        addr_q  <= req_addr[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
        rw_q    <= req_rw[pick_idx];
        mem_q   <= req_mem_addr[int'(pick_idx)*I2C_MEM_W +: I2C_MEM_W];
        wdata_q <= req_wdata[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
      end
      if (to_resp) begin
        done_q        <= gnt_q;
        rsp_data_q    <= m_data_rd;
        rsp_ack_err_q <= m_ack_err;
        rsp_timeout_q <= to_hit;
      end
      if (state_q == RESP) begin
        gnt_q <= '0;
        ptr_q <= PW'((int'(gidx_q) + 1) % NREQ);
      end
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_ack_err = rsp_ack_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign m_addr      = addr_q;
  assign m_rw        = rw_q;
  assign m_mem_addr  = mem_q;
  assign m_data_wr   = wdata_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;

  localparam int NREQ    = 4;
  localparam int BUSY_TO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [5*NREQ-1:0] req_mem_addr = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rsp_data;
  logic              rsp_ack_err, rsp_timeout;
  logic              m_en, m_rw;
  logic [6:0]        m_addr;
  logic [4:0]        m_mem_addr;
  logic [7:0]        m_data_wr;
  logic [7:0]        m_data_rd = '0;
  logic              m_ack_err = 1'b0;
  logic              m_busy = 1'b0;

  i2c_cmd_arbiter #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_mem_addr(req_mem_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
    .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw), .m_mem_addr(m_mem_addr),
    .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_ack_err(m_ack_err), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Master behaviour settings; cfg_L < 0 selects random per transaction.
  int         cfg_L = 1;
  int         cfg_B = 1;
  logic [7:0] cfg_rd = '0;
  logic       cfg_ack = 1'b0;
  int         en_count = 0;

  // Transaction-level reference: each grant becomes a schedule computed from the rules.
  bit         started = 0;
  bit         own = 0;
  int         ptr = 0;
  int         w = 0;
  int         t_dec = -10;
  int         t_done = -10;
  int         plan_L, plan_B;
  logic [7:0] plan_rd;
  logic       plan_ack, plan_to;
  logic [6:0] pend_addr, cur_addr = '0;
  logic       pend_rw, cur_rw = 1'b0;
  logic [4:0] pend_mem, cur_mem = '0;
  logic [7:0] pend_wd, cur_wd = '0;
  logic [7:0] e_rsp_d = '0;
  logic       e_rsp_a = 1'b0, e_rsp_t = 1'b0;
  logic [NREQ-1:0] e_gnt, e_done;
  logic       e_en;

  bit         en_valid = 0;
  int         en_cyc = 0, mL = 0, mB = 0;

  always @(negedge clk) begin
    if (started) begin
      if (own && cyc == t_dec + 1) begin
        cur_addr = pend_addr; cur_rw = pend_rw; cur_mem = pend_mem; cur_wd = pend_wd;
      end
      if (own && cyc == t_done) begin
        e_rsp_d = plan_rd; e_rsp_a = plan_ack; e_rsp_t = plan_to;
      end
      e_gnt  = (own && cyc > t_dec && cyc <= t_done) ? NREQ'(1 << w) : '0;
      e_done = (own && cyc == t_done) ? NREQ'(1 << w) : '0;
      e_en   = own && (cyc == t_dec + 1);
      chk("gnt", gnt, e_gnt);
      chk("done", done, e_done);
      chk("m_en", m_en, e_en);
      chk("m_addr", m_addr, cur_addr);
      chk("m_rw", m_rw, cur_rw);
      chk("m_mem_addr", m_mem_addr, cur_mem);
      chk("m_data_wr", m_data_wr, cur_wd);
      chk("rsp_data", rsp_data, e_rsp_d);
      chk("rsp_ack_err", rsp_ack_err, e_rsp_a);
      chk("rsp_timeout", rsp_timeout, e_rsp_t);
    end
    // i2c_master stand-in reacting to the launch pulse
    if (rst) begin
      en_valid = 0;
      m_busy = 1'b0;
    end else begin
      if (m_en === 1'b1) begin
        en_valid = 1; en_cyc = cyc; mL = plan_L; mB = plan_B;
        m_data_rd = plan_rd; m_ack_err = plan_ack;
        en_count++;
      end
      m_busy = en_valid && (cyc >= en_cyc + mL) && (cyc < en_cyc + mL + mB);
    end
    // reference decision for this cycle
    if (rst) begin
      started = 1; own = 0; ptr = 0; t_dec = -10; t_done = -10;
      cur_addr = '0; cur_rw = 1'b0; cur_mem = '0; cur_wd = '0;
      e_rsp_d = '0; e_rsp_a = 1'b0; e_rsp_t = 1'b0;
    end else if (started && (!own || cyc > t_done) && req != '0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
      t_dec = cyc;
      pend_addr = req_addr[w*7 +: 7];
      pend_rw   = req_rw[w];
      pend_mem  = req_mem_addr[w*5 +: 5];
      pend_wd   = req_wdata[w*8 +: 8];
      if (cfg_L < 0) begin
        case ($urandom_range(0, 9))
          0:       plan_L = 1000;
          1:       plan_L = BUSY_TO;
          default: plan_L = $urandom_range(1, 4);
        endcase
        plan_B = $urandom_range(1, 12);
        plan_rd = 8'($urandom);
        plan_ack = 1'($urandom_range(0, 1));
      end else begin
        plan_L = cfg_L; plan_B = cfg_B; plan_rd = cfg_rd; plan_ack = cfg_ack;
      end
      plan_to = (plan_L > BUSY_TO);
      t_done = plan_to ? t_dec + 2 + BUSY_TO : t_dec + 2 + plan_L + plan_B;
      ptr = (w + 1) % NREQ;
      own = 1;
    end
  end

  // Requester side: drop at done unless told to re-assert; random traffic when enabled.
  logic [NREQ-1:0] reassert = '0;
  bit              rand_mode = 0;

  task automatic set_fields(input int i, input logic [6:0] a, input logic rw,
                            input logic [4:0] ma, input logic [7:0] wd);
    req_addr[i*7 +: 7]     = a;
    req_rw[i]              = rw;
    req_mem_addr[i*5 +: 5] = ma;
    req_wdata[i*8 +: 8]    = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (done[i] && !reassert[i]) begin
        req[i] = 1'b0;
      end else if (rand_mode) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            set_fields(i, 7'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
            req[i] = 1'b1;
          end
        end else if (gnt[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_fields(i, 7'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done(input string name, output int idx, output int at);
    idx = -1;
    at = -1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (done != '0) begin
        for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
        at = cyc;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: no done within 2000 cycles", name);
  endtask

  int idx, at, c0, e0;
  int exp_fair[4];

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_gnt", gnt, 0);
    chk("reset_done", done, 0);
    chk("reset_m_en", m_en, 0);
    chk("reset_m_addr", m_addr, 0);
    chk("reset_m_data_wr", m_data_wr, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_flags", {rsp_ack_err, rsp_timeout}, 0);
    rst = 1'b0;
    tick();

    // single request, busy 200 cycles
    cfg_L = 1; cfg_B = 200; cfg_rd = 8'h5A; cfg_ack = 1'b0;
    set_fields(0, 7'd2, 1'b1, 5'd0, 8'h00);
    req[0] = 1'b1;
    c0 = cyc;
    e0 = en_count;
    tick();
    chk("single_en_cycle1", m_en, 1);
    chk("single_gnt_cycle1", gnt, 4'b0001);
    wait_done("single", idx, at);
    chk("single_idx", idx, 0);
    chk("single_latency", at - c0, 203);
    chk("single_m_fields", {m_addr, m_rw, m_mem_addr, m_data_wr}, {7'd2, 1'b1, 5'd0, 8'h00});
    chk("single_en_count", en_count - e0, 1);
    chk("single_ack_err", rsp_ack_err, 0);

    // contention from pointer 0
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cfg_B = 3;
    for (int i = 0; i < NREQ; i++) set_fields(i, 7'($urandom), 1'($urandom), 5'(i), 8'(i * 17));
    req = 4'b1111;
    e0 = en_count;
    for (int k = 0; k < NREQ; k++) begin
      wait_done("contention", idx, at);
      chk("contention_order", idx, k);
      chk("contention_mem_addr", m_mem_addr, k);
      chk("contention_wdata", m_data_wr, k * 17);
    end
    chk("contention_en_count", en_count - e0, 4);

    // fairness: 0 re-asserts immediately, 2 stays pending
    exp_fair = '{0, 2, 0, 2};
    reassert = 4'b0101;
    req[0] = 1'b1;
    req[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done("fairness", idx, at);
      chk("fairness_order", idx, exp_fair[k]);
    end
    reassert = '0;
    req = '0;

    // read return with ack error
    cfg_L = 1; cfg_B = 5; cfg_rd = 8'h33; cfg_ack = 1'b1;
    set_fields(1, 7'h50, 1'b0, 5'd7, 8'h00);
    req[1] = 1'b1;
    wait_done("read", idx, at);
    chk("read_idx", idx, 1);
    chk("read_rsp_data", rsp_data, 8'h33);
    chk("read_ack_err", rsp_ack_err, 1);
    chk("read_timeout", rsp_timeout, 0);
    repeat (5) tick();
    chk("read_rsp_held", {rsp_data, rsp_ack_err}, {8'h33, 1'b1});

    // start timeout, then the next pending requester
    cfg_L = 1000; cfg_ack = 1'b0;
    req[3] = 1'b1;
    req[1] = 1'b1;
    c0 = cyc;
    wait_done("timeout", idx, at);
    chk("timeout_idx", idx, 3);
    chk("timeout_latency", at - c0, BUSY_TO + 2);
    chk("timeout_flag", rsp_timeout, 1);
    tick();
    chk("timeout_gap_gnt", gnt, 0);
    tick();
    chk("timeout_next_gnt", gnt, 4'b0010);
    wait_done("timeout_next", idx, at);
    chk("timeout_next_idx", idx, 1);

    // reset while the master is busy
    cfg_L = 1; cfg_B = 30;
    tick();
    req[2] = 1'b1;
    repeat (10) tick();
    req[1] = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_gnt", gnt, 0);
    chk("midrst_m_en", m_en, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    tick();
    chk("midrst_regrant", gnt, 4'b0010);
    wait_done("midrst_first", idx, at);
    chk("midrst_first_idx", idx, 1);
    wait_done("midrst_second", idx, at);
    chk("midrst_second_idx", idx, 2);

    // random traffic checked cycle by cycle against the reference
    cfg_L = -1;
    rand_mode = 1;
    repeat (4000) tick();
    rand_mode = 0;
    for (int n = 0; n < 3000 && (req != '0 || gnt != '0); n++) tick();
    chk("drain_idle", {req, gnt}, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
